// File: rtl/if_prefetch_stage.sv
// Instruction fetch stage: keeps a DEPTH-entry prefetch queue in front of decode filled
// from an icache-style read/valid port. Redirects flush the queue; an in-flight read is drained.
module if_prefetch_stage #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          BP_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        branch_i,
  input  logic [31:0] pc_i,
  input  logic        halt_i,
  input  logic        ack_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        br_pred_o,
  output logic        mem_read_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_data_i,
  input  logic        bp_taken_i,
  input  logic [31:0] bp_target_i,
  output logic [31:0] dbg_pc_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DISCARD} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } entry_t;

  state_t         state_q, state_d;
  entry_t         fifo_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic [31:0]    pc_q, req_addr_q;
  logic           redirect, issue, push, pop, pred;
  logic [31:0]    pc_next;

  assign redirect = flush_i | branch_i;
  assign pred     = BP_EN && bp_taken_i;
  assign pc_next  = pred ? bp_target_i : pc_q + 32'd4;
  assign pop      = ack_i && valid_o && !redirect;

  // Head of queue and debug PC come straight from registers
  assign valid_o   = (count_q != '0);
  assign instr_o   = fifo_q[rd_ptr_q].instr;
  assign pc_o      = fifo_q[rd_ptr_q].pc;
  assign br_pred_o = fifo_q[rd_ptr_q].pred;
  assign dbg_pc_o  = pc_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and memory request; redirect suppresses push and new issue
  always_comb begin
    state_d    = state_q;
    mem_read_o = 1'b0;
    mem_addr_o = pc_q;
    issue      = 1'b0;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        issue      = (count_q < CW'(DEPTH)) && !halt_i && !redirect && !rst_i;
        mem_read_o = issue;
        push       = issue && mem_valid_i;
        if (issue && !mem_valid_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read_o = 1'b1;
        mem_addr_o = req_addr_q;
        if (mem_valid_i) begin
          push    = !redirect;
          state_d = S_IDLE;
        end else if (redirect) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        mem_read_o = 1'b1;
        mem_addr_o = req_addr_q;
        if (mem_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Queue storage, pointers, fetch PC
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (issue && !mem_valid_i) req_addr_q <= pc_q;
      if (redirect) begin
        pc_q     <= pc_i;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          fifo_q[wr_ptr_q] <= '{instr: mem_data_i, pc: pc_q, pred: pred};
          wr_ptr_q         <= wr_ptr_q + PW'(1);
          pc_q             <= pc_next;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: directed scenarios plus a randomized run checked against
// a program-order fetch-stream model driven by a bench-side memory and predictor.
module tb_if_prefetch_stage;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, branch_i, halt_i, ack_i;
  logic [31:0] pc_i;
  logic        valid_o, br_pred_o, mem_read_o, mem_valid_i, bp_taken_i;
  logic [31:0] instr_o, pc_o, mem_addr_o, mem_data_i, bp_target_i, dbg_pc_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat      = 0;
  int          wait_cnt;
  int          bp_mode  = 0;
  logic [31:0] bp_addr  = 32'h0;
  logic [31:0] bp_tgt   = 32'h0;

  always #5 clk = ~clk;

  if_prefetch_stage #(.DEPTH(4), .RESET_PC(32'h0), .BP_EN(1'b1)) dut (
    .clk(clk), .rst_i(rst_i), .flush_i(flush_i), .branch_i(branch_i), .pc_i(pc_i),
    .halt_i(halt_i), .ack_i(ack_i), .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o),
    .br_pred_o(br_pred_o), .mem_read_o(mem_read_o), .mem_addr_o(mem_addr_o),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i), .bp_taken_i(bp_taken_i),
    .bp_target_i(bp_target_i), .dbg_pc_o(dbg_pc_o)
  );

  // Memory: answers after 'lat' cycles of held request; data is a fixed function of address
  assign mem_valid_i = mem_read_o && (wait_cnt >= lat);
  assign mem_data_i  = mem_addr_o ^ KEY;
  always @(posedge clk or posedge rst_i) begin
    if (rst_i)                           wait_cnt <= 0;
    else if (!mem_read_o || mem_valid_i) wait_cnt <= 0;
    else                                 wait_cnt <= wait_cnt + 1;
  end

  assign bp_taken_i  = (bp_mode == 1 && mem_addr_o == bp_addr) ||
                       (bp_mode == 2 && mem_addr_o[5:2] == 4'd11);
  assign bp_target_i = (bp_mode == 1) ? bp_tgt : mem_addr_o + 32'h100;

  function automatic logic model_taken(logic [31:0] a);
    return (bp_mode == 1 && a == bp_addr) || (bp_mode == 2 && a[5:2] == 4'd11);
  endfunction

  function automatic logic [31:0] model_next(logic [31:0] a);
    if (!model_taken(a)) return a + 32'd4;
    return (bp_mode == 1) ? bp_tgt : a + 32'h100;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; flush_i = 1'b0; branch_i = 1'b0; halt_i = 1'b0; ack_i = 1'b0;
    pc_i = 32'h0; lat = 0; bp_mode = 0;
    repeat (2) next_cycle();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; branch_i = 1'b0; halt_i = 1'b0; ack_i = 1'b1;
    pc_i = 32'h0; lat = 0; bp_mode = 0;
    repeat (2) next_cycle();
    @(negedge clk);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    n_checks++; if (instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", instr_o); end
    n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", pc_o); end
    n_checks++; if (br_pred_o !== 1'b0) begin n_fail++; $display("FAIL reset_pred got %b exp 0", br_pred_o); end
    n_checks++; if (mem_read_o !== 1'b0) begin n_fail++; $display("FAIL reset_read got %b exp 0", mem_read_o); end
    n_checks++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", mem_addr_o); end
    n_checks++; if (dbg_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_dbg got %h exp 0", dbg_pc_o); end
    next_cycle();
  endtask

  task automatic test_stream();
    do_reset();
    ack_i = 1'b1;
    next_cycle();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %b exp 1", k, valid_o); end
      n_checks++; if (pc_o !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_pc[%0d] got %h exp %h", k, pc_o, 32'(4 * k)); end
      n_checks++; if (instr_o !== (32'(4 * k) ^ KEY)) begin n_fail++; $display("FAIL stream_instr[%0d] got %h exp %h", k, instr_o, 32'(4 * k) ^ KEY); end
      next_cycle();
    end
  endtask

  task automatic test_full();
    int n_done;
    do_reset();
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_read_o && mem_valid_i) n_done++;
      next_cycle();
    end
    @(negedge clk);
    n_checks++; if (n_done !== 4) begin n_fail++; $display("FAIL full_reads got %0d exp 4", n_done); end
    n_checks++; if (mem_read_o !== 1'b0) begin n_fail++; $display("FAIL full_read got %b exp 0", mem_read_o); end
    n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0) begin n_fail++; $display("FAIL full_head got v=%b pc=%h exp v=1 pc=0", valid_o, pc_o); end
    next_cycle();
    ack_i = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_read_o !== 1'b0) begin n_fail++; $display("FAIL full_ack_read got %b exp 0", mem_read_o); end
    next_cycle();
    ack_i = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_read_o !== 1'b1 || mem_addr_o !== 32'h10) begin n_fail++; $display("FAIL full_resume got rd=%b addr=%h exp rd=1 addr=10", mem_read_o, mem_addr_o); end
    n_checks++; if (pc_o !== 32'h4) begin n_fail++; $display("FAIL full_head_after_pop got %h exp 4", pc_o); end
    next_cycle();
  endtask

  task automatic test_flush();
    bit seen;
    do_reset();
    lat = 3;
    flush_i = 1'b1; pc_i = 32'h20;
    @(negedge clk);
    n_checks++; if (mem_read_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle_read got %b exp 0", mem_read_o); end
    next_cycle();
    flush_i = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_read_o !== 1'b1 || mem_addr_o !== 32'h20) begin n_fail++; $display("FAIL flush_req20 got rd=%b addr=%h", mem_read_o, mem_addr_o); end
    next_cycle();
    flush_i = 1'b1; pc_i = 32'h100;
    for (int c = 2; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (mem_read_o !== 1'b1 || mem_addr_o !== 32'h20) begin n_fail++; $display("FAIL flush_hold[%0d] got rd=%b addr=%h exp rd=1 addr=20", c, mem_read_o, mem_addr_o); end
      if (c > 2) begin
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_empty[%0d] got %b exp 0", c, valid_o); end
      end
      next_cycle();
      flush_i = 1'b0;
    end
    @(negedge clk);
    n_checks++; if (mem_read_o !== 1'b1 || mem_addr_o !== 32'h100) begin n_fail++; $display("FAIL flush_newreq got rd=%b addr=%h exp rd=1 addr=100", mem_read_o, mem_addr_o); end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      next_cycle();
      @(negedge clk);
      seen = valid_o;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL flush_timeout got valid=0 exp valid=1 within 20 cycles"); end
    n_checks++; if (pc_o !== 32'h100 || instr_o !== (32'h100 ^ KEY)) begin n_fail++; $display("FAIL flush_first got pc=%h instr=%h exp pc=100", pc_o, instr_o); end
    next_cycle();
  endtask

  task automatic test_bp();
    logic [31:0] exp_pc [5] = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h44};
    logic        exp_pr [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    ack_i = 1'b1; bp_mode = 1; bp_addr = 32'h8; bp_tgt = 32'h40;
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (valid_o !== 1'b1 || pc_o !== exp_pc[k] || br_pred_o !== exp_pr[k]) begin
        n_fail++; $display("FAIL bp[%0d] got v=%b pc=%h pred=%b exp v=1 pc=%h pred=%b", k, valid_o, pc_o, br_pred_o, exp_pc[k], exp_pr[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_halt();
    do_reset();
    lat = 3;
    next_cycle();
    halt_i = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_read_o !== 1'b1 || mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL halt_outstanding got rd=%b addr=%h exp rd=1 addr=0", mem_read_o, mem_addr_o); end
    for (int c = 2; c < 9; c++) begin
      next_cycle();
      @(negedge clk);
      if (c >= 4) begin
        n_checks++; if (mem_read_o !== 1'b0) begin n_fail++; $display("FAIL halt_noread[%0d] got %b exp 0", c, mem_read_o); end
      end
    end
    n_checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0) begin n_fail++; $display("FAIL halt_enq got v=%b pc=%h exp v=1 pc=0", valid_o, pc_o); end
    next_cycle();
    halt_i = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_read_o !== 1'b1 || mem_addr_o !== 32'h4) begin n_fail++; $display("FAIL halt_resume got rd=%b addr=%h exp rd=1 addr=4", mem_read_o, mem_addr_o); end
    next_cycle();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    do_reset();
    ack_i = 1'b1; flush_i = 1'b1; pc_i = 32'hFFFF_FFF8;
    next_cycle();
    flush_i = 1'b0;
    @(negedge clk);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL wrap_empty got %b exp 0", valid_o); end
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (valid_o !== 1'b1 || pc_o !== exp_pc[k]) begin n_fail++; $display("FAIL wrap[%0d] got v=%b pc=%h exp pc=%h", k, valid_o, pc_o, exp_pc[k]); end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    lat = 1;
    repeat (2) next_cycle();
    @(negedge clk);
    n_checks++; if (valid_o !== 1'b1 || mem_read_o !== 1'b1) begin n_fail++; $display("FAIL areset_pre got v=%b rd=%b exp 1 1", valid_o, mem_read_o); end
    #2;
    rst_i = 1'b1;
    #1;
    n_checks++; if (valid_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 32'h0 || br_pred_o !== 1'b0) begin
      n_fail++; $display("FAIL areset_head got v=%b instr=%h pc=%h pred=%b exp all 0", valid_o, instr_o, pc_o, br_pred_o);
    end
    n_checks++; if (mem_read_o !== 1'b0 || mem_addr_o !== 32'h0 || dbg_pc_o !== 32'h0) begin
      n_fail++; $display("FAIL areset_mem got rd=%b addr=%h dbg=%h exp 0 0 0", mem_read_o, mem_addr_o, dbg_pc_o);
    end
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_read_o !== 1'b1 || mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL areset_first got rd=%b addr=%h exp rd=1 addr=0", mem_read_o, mem_addr_o); end
    next_cycle();
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    bit          chk_empty;
    int          pops;
    do_reset();
    bp_mode = 2;
    exp_pc = 32'h0; chk_empty = 1'b0; pops = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      int r;
      r = $urandom_range(0, 29);
      lat      = $urandom_range(0, 2);
      ack_i    = 1'($urandom_range(0, 1));
      halt_i   = ($urandom_range(0, 4) == 0);
      flush_i  = (r == 0);
      branch_i = (r == 1);
      pc_i     = 32'($urandom_range(0, 255)) << 2;
      @(negedge clk);
      if (chk_empty) begin
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rnd_redirect_empty@%0d got %b exp 0", cyc, valid_o); end
      end
      chk_empty = flush_i || branch_i;
      if (flush_i || branch_i) begin
        exp_pc = pc_i;
      end else if (valid_o && ack_i) begin
        n_checks++;
        if (pc_o !== exp_pc || instr_o !== (exp_pc ^ KEY) || br_pred_o !== model_taken(exp_pc)) begin
          n_fail++;
          $display("FAIL rnd_pop@%0d got pc=%h instr=%h pred=%b exp pc=%h instr=%h pred=%b",
                   cyc, pc_o, instr_o, br_pred_o, exp_pc, exp_pc ^ KEY, model_taken(exp_pc));
        end
        exp_pc = model_next(exp_pc);
        pops++;
      end
      next_cycle();
    end
    flush_i = 1'b0; branch_i = 1'b0; halt_i = 1'b0; ack_i = 1'b0;
    n_checks++; if (pops < 50) begin n_fail++; $display("FAIL rnd_progress got %0d pops exp >= 50", pops); end
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; branch_i = 1'b0; halt_i = 1'b0; ack_i = 1'b0; pc_i = 32'h0;
    next_cycle();
    test_reset();
    test_stream();
    test_full();
    test_flush();
    test_bp();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
